// File: rtl/cflog_reader.sv
// ============================================================================
//  Module      : cflog_reader
//  Description : Drains the control-flow log memory on a flush request and
//                streams each 16-bit entry out on a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cflog_reader #(
  parameter logic [15:0] LOG_SIZE = 16'h0100,
  parameter int          MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [15:0] log_ptr,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        drain_busy,
  output logic        drain_done,
  output logic [15:0] entries_sent
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] c_lat_last = 4'(MEM_LAT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_flush_d;
  logic [15:0] r_end_ptr;
  logic [15:0] r_rd_ptr;
  logic [3:0]  r_lat_cnt;
  logic [15:0] r_tx_data;
  logic        r_tx_last;
  logic        r_busy;
  logic [15:0] r_entries;

  logic        w_start;
  logic        w_lat_hit;
  logic [15:0] w_end_ptr_clamp;

  assign w_start         = flush & ~r_flush_d;
  assign w_lat_hit       = (r_lat_cnt == c_lat_last);
  // Odd pointers round down so a half-written entry is never sent.
  assign w_end_ptr_clamp = ((log_ptr > LOG_SIZE) ? LOG_SIZE : log_ptr) & 16'hFFFE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = (w_end_ptr_clamp == 16'd0) ? S_DONE : S_RD;
        end
      end
      S_RD:   w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_lat_hit) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          w_state_nxt = r_tx_last ? S_DONE : S_RD;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flush_d <= 1'b0;
      r_end_ptr <= 16'd0;
      r_rd_ptr  <= 16'd0;
      r_lat_cnt <= 4'd0;
      r_tx_data <= 16'd0;
      r_tx_last <= 1'b0;
      r_busy    <= 1'b0;
      r_entries <= 16'd0;
    end else begin
      r_flush_d <= flush;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_end_ptr <= w_end_ptr_clamp;
            r_rd_ptr  <= 16'd0;
            r_entries <= 16'd0;
            r_busy    <= 1'b1;
          end
        end
        S_RD: begin
          r_lat_cnt <= 4'd0;
        end
        S_WAIT: begin
          if (w_lat_hit) begin
            r_tx_data <= mem_rdata;
            r_tx_last <= ((r_rd_ptr + 16'd2) == r_end_ptr);
          end else begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            r_entries <= r_entries + 16'd1;
            r_rd_ptr  <= r_rd_ptr + 16'd2;
          end
        end
        S_DONE: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_en    = (r_state == S_RD);
  assign mem_addr     = mem_rd_en ? r_rd_ptr : 16'd0;
  assign tx_valid     = (r_state == S_SEND);
  assign tx_data      = r_tx_data;
  assign tx_last      = r_tx_last;
  assign drain_busy   = r_busy;
  assign drain_done   = (r_state == S_DONE);
  assign entries_sent = r_entries;

endmodule

`default_nettype wire
